adc_spi_capture_mc: RTL and testbench
=====================================

Name: adc_spi_capture_mc

Overview:
Parametrised OPB-slave capture engine for SPI-output SAR ADCs (ADS8864 class), the multi-channel successor to the single-channel ADS8864 interface. Drives a shared CNVST/SCLK to NCH parallel ADCs, each with its own SDOUT. Writes samples into an internal capture RAM readable over OPB. Adds a programmable sample period, single-shot or continuous (wrapping) capture, abort, and W1C status flags.

Parameters:
NCH, 1, number of ADCs sharing CNVST/SCLK (1..8)
RES, 16, ADC resolution in bits (8..24)
DEPTH, 1024, capture RAM depth in 32-bit words (power of 2, multiple of NCH)
T_CONV, 70, OPB_CLK cycles CNVST is held high (conversion time)
AW, $clog2(DEPTH), RAM word-address width (derived)

Ports:
OPB_CLK  in  1  single clock for bus and capture logic
OPB_RST_N  in  1  asynchronous active-low reset
OPB_ADDR  in  32  byte address; ADDR[11]=1 selects registers, ADDR[11]=0 selects RAM word ADDR[AW+1:2]
OPB_DI  in  32  write data
OPB_WE  in  1  write strobe, one cycle
OPB_RE  in  1  read strobe
OPB_DO  out  32  read data, zero when not reading
ADC_CNVST  out  1  conversion start, shared
ADC_SCLK  out  1  serial clock, shared, idles low
ADC_SDOUT  in  NCH  serial data, one bit per ADC

Behaviour:
- Reset (async, OPB_RST_N=0): state IDLE; ADC_CNVST=0, ADC_SCLK=0, OPB_DO=0; CONTROL=0; CONFIG: SCLK_HALF=1, PERIOD=200; COUNT=0; STATUS=0; write pointer=0. RAM contents not reset. Reset mid-frame aborts immediately; no partial word written.
- Register map:
  - 0x800 CONTROL: bit0 ABORT (self-clear); bit1 START (self-clear, reads 0); bit2 CONT.
  - 0x804 CONFIG: [7:0] SCLK_HALF (0 treated as 1); [31:16] PERIOD (cycles between CNVST rising edges).
  - 0x808 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 WRAP (sticky, W1C); [31:16] WPTR (zero-extended).
  - 0x80C COUNT: [AW-1:0] sample sets for single-shot; 0 means DEPTH/NCH.
  - Unmapped addresses read 0.
- Read timing: OPB_DO registered on the edge where OPB_RE=1; valid during the following cycle; 0 otherwise. RAM is read synchronously, one-cycle latency, same timing.
- FSM:
  - IDLE: START -> CONV; clear WPTR and DONE; load period counter.
  - CONV: CNVST=1 for T_CONV cycles -> ACQ.
  - ACQ: RES SCLK pulses, each high SCLK_HALF and low SCLK_HALF cycles, MSB first. SDOUT[ch] shifted into per-channel register on the cycle SCLK is driven high->low -> STORE.
  - STORE: NCH consecutive cycles write channel ch, sample zero-extended to 32, at WPTR+ch; WPTR += NCH -> GAP.
  - GAP: wait until PERIOD cycles since last CNVST rise, then CONV. If PERIOD is shorter than the frame length, frames run back-to-back with no wait.
  - Single-shot: after COUNT sets -> IDLE; set DONE.
  - CONT: WPTR wraps to 0 at DEPTH and sets WRAP; runs until ABORT.
- ABORT in any non-IDLE state: -> IDLE next cycle, CNVST/SCLK low, DONE set, current set discarded.
- START while BUSY is ignored.
- Simultaneous START and ABORT: ABORT wins.
- CONT cleared during a run: finish the current set, then -> IDLE with DONE set.
- BUSY=1 in every state except IDLE.
- CPU RAM reads during capture are allowed; the capture write has priority, and the read returns old or new data.

Optional Feature:
ADC_TESTPAT_EN
- Defined: CONTROL bit3 TESTPAT (RW). When set, STORE writes {8'(ch), 8'hA5, 16'(set index)} in place of shifted data; SCLK/CNVST timing is unchanged.
- Undefined: bit3 reads 0, writes are ignored, no pattern logic is built.

Decomposition:
- Shared package adc_capture_pkg: register offsets (0x800/0x804/0x808/0x80C), CONTROL/STATUS bit indices, FSM state enum, reset defaults (SCLK_HALF=1, PERIOD=200).
- One sub-module adc_serial_shifter: SCLK generation plus NCH×RES shift registers, with start/done handshake.
- Capture RAM is an inferred dual-port array in the top level.

Test Plan:
- NCH=2, RES=16, models return 16'h1234/16'hABCD, COUNT=4, START -> DONE=1, BUSY=0, RAM words 0..7 alternate 0x1234/0xABCD.
- PERIOD=200, SCLK_HALF=2 -> CNVST rising edges exactly 200 clocks apart, SCLK period 4 clocks, 16 pulses per frame.
- CONT=1, DEPTH=16, NCH=2 -> after 9 sets WRAP=1 and WPTR=2; write STATUS 0x4 -> WRAP=0.
- ABORT during ACQ -> next cycle BUSY=0, SCLK=0, CNVST=0; WPTR unchanged since last STORE.
- OPB_RST_N low for 1 cycle mid-CONV -> all outputs at reset values; subsequent START captures normally.
- ADC_TESTPAT_EN defined, TESTPAT=1, COUNT=3, NCH=2 -> RAM[5]=0x01A50002; macro undefined -> CONTROL readback bit3=0.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the multi-channel SAR ADC capture engine:
// register offsets, CONTROL/STATUS bit positions, FSM states and reset defaults.
package adc_capture_pkg;

  localparam logic [11:0] REG_CONTROL = 12'h800;
  localparam logic [11:0] REG_CONFIG  = 12'h804;
  localparam logic [11:0] REG_STATUS  = 12'h808;
  localparam logic [11:0] REG_COUNT   = 12'h80C;

  localparam int unsigned CTRL_ABORT   = 0;
  localparam int unsigned CTRL_START   = 1;
  localparam int unsigned CTRL_CONT    = 2;
  localparam int unsigned CTRL_TESTPAT = 3;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_WRAP = 2;

  localparam logic [7:0]  SCLK_HALF_RST = 8'd1;
  localparam logic [15:0] PERIOD_RST    = 16'd200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_ACQ,
    S_STORE,
    S_GAP
  } cap_state_t;

endpackage

// File: rtl/adc_serial_shifter.sv
// Shared SCLK generator and NCH parallel MSB-first shift registers.
// start launches RES pulses; done is high in the final low-phase cycle.
module adc_serial_shifter #(
  parameter int unsigned NCH = 1,
  parameter int unsigned RES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               sclk_half,
  input  logic [NCH-1:0]           sdout,
  output logic                     sclk,
  output logic                     done,
  output logic [NCH-1:0][RES-1:0]  data
);

  localparam int unsigned BW = $clog2(RES);

  logic          active_q;
  logic          sclk_q;
  logic [7:0]    cnt_q;
  logic [BW-1:0] bit_q;
  logic [7:0]    half;
  logic          phase_end;
  logic [NCH-1:0][RES-1:0] data_q;

  assign half      = (sclk_half == 8'd0) ? 8'd1 : sclk_half;
  assign phase_end = active_q && (cnt_q >= half - 8'd1);
  assign done      = phase_end && !sclk_q && (bit_q == BW'(RES - 1));
  assign sclk      = sclk_q;
  assign data      = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
    end else if (abort) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
    end else if (start) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else if (active_q) begin
      if (!phase_end) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
        if (sclk_q) begin
          // Capture on the edge where SCLK is driven high->low.
          sclk_q <= 1'b0;
          for (int unsigned c = 0; c < NCH; c++)
            data_q[c] <= {data_q[c][RES-2:0], sdout[c]};
        end else if (bit_q == BW'(RES - 1)) begin
          active_q <= 1'b0;
        end else begin
          sclk_q <= 1'b1;
          bit_q  <= bit_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_spi_capture_mc.sv
// OPB-slave capture engine for NCH SPI SAR ADCs sharing CNVST/SCLK, with capture RAM.
// Optional ADC_TESTPAT_EN builds the CONTROL.TESTPAT synthetic-data path.
module adc_spi_capture_mc
  import adc_capture_pkg::*;
#(
  parameter int unsigned NCH    = 1,
  parameter int unsigned RES    = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned T_CONV = 70,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic           OPB_CLK,
  input  logic           OPB_RST_N,
  input  logic [31:0]    OPB_ADDR,
  input  logic [31:0]    OPB_DI,
  input  logic           OPB_WE,
  input  logic           OPB_RE,
  output logic [31:0]    OPB_DO,
  output logic           ADC_CNVST,
  output logic           ADC_SCLK,
  input  logic [NCH-1:0] ADC_SDOUT
);

  localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CVW      = (T_CONV > 1) ? $clog2(T_CONV) : 1;
  localparam int unsigned SW       = AW + 1;
  localparam int unsigned SETS_MAX = DEPTH / NCH;

  cap_state_t state_q, state_d;

  logic           ctrl_cont_q;
  logic           ctrl_testpat_q;
  logic [7:0]     cfg_sclk_half_q;
  logic [15:0]    cfg_period_q;
  logic [AW-1:0]  count_q;
  logic           st_done_q;
  logic           st_wrap_q;
  logic [AW-1:0]  wptr_q;
  logic [SW-1:0]  set_idx_q;
  logic           run_cont_q;
  logic           cnvst_q;
  logic [CVW-1:0] conv_cnt_q;
  logic [15:0]    period_cnt_q;
  logic [CHW-1:0] st_ch_q;

  logic [11:0] reg_off;
  logic        wr_ctrl, wr_cfg, wr_status, wr_count;
  logic        abort_req, start_req, abort_run, ctrl_cont_nxt;
  logic        shift_start, shift_done, shift_sclk;
  logic [NCH-1:0][RES-1:0] shift_data;
  logic [SW-1:0] count_eff;
  logic [AW:0]   wptr_nxt;
  logic          period_up, run_end, set_end;
  logic [RES-1:0] sample;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram [DEPTH];
  logic [31:0]   ram_q;
  logic [31:0]   reg_rdata;
  logic [31:0]   do_reg_q;
  logic          rd_ram_q;
  logic          unused_ok;

  assign unused_ok = ^{OPB_ADDR[31:12], OPB_DI};

  assign reg_off   = OPB_ADDR[11:0];
  assign wr_ctrl   = OPB_WE && (reg_off == REG_CONTROL);
  assign wr_cfg    = OPB_WE && (reg_off == REG_CONFIG);
  assign wr_status = OPB_WE && (reg_off == REG_STATUS);
  assign wr_count  = OPB_WE && (reg_off == REG_COUNT);
  assign abort_req = wr_ctrl && OPB_DI[CTRL_ABORT];
  assign start_req = wr_ctrl && OPB_DI[CTRL_START];
  assign abort_run = abort_req && (state_q != S_IDLE);
  assign ctrl_cont_nxt = wr_ctrl ? OPB_DI[CTRL_CONT] : ctrl_cont_q;

  assign count_eff = (count_q == '0) ? SW'(SETS_MAX) : SW'(count_q);
  assign wptr_nxt  = {1'b0, wptr_q} + (AW + 1)'(NCH);
  // Period counter restarts on each CNVST rise; saturation keeps long gaps sane.
  assign period_up = (17'(period_cnt_q) + 17'd1) >= 17'(cfg_period_q);
  assign run_end   = run_cont_q ? !ctrl_cont_q : ((set_idx_q + SW'(1)) == count_eff);
  assign set_end   = (state_q == S_STORE) && (st_ch_q == CHW'(NCH - 1)) && !abort_req;

  always_comb begin
    state_d     = state_q;
    shift_start = 1'b0;
    if (abort_run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_req && !abort_req) state_d = S_CONV;
        S_CONV:  if (conv_cnt_q == CVW'(T_CONV - 1)) begin
                   state_d     = S_ACQ;
                   shift_start = 1'b1;
                 end
        S_ACQ:   if (shift_done) state_d = S_STORE;
        S_STORE: if (st_ch_q == CHW'(NCH - 1)) begin
                   if (run_end)        state_d = S_IDLE;
                   else if (period_up) state_d = S_CONV;
                   else                state_d = S_GAP;
                 end
        S_GAP:   if (period_up) state_d = S_CONV;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q      <= S_IDLE;
      cnvst_q      <= 1'b0;
      conv_cnt_q   <= '0;
      period_cnt_q <= '0;
      st_ch_q      <= '0;
      set_idx_q    <= '0;
      wptr_q       <= '0;
      run_cont_q   <= 1'b0;
      st_done_q    <= 1'b0;
      st_wrap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnvst_q <= (state_d == S_CONV);
      st_ch_q <= (state_q == S_STORE && state_d == S_STORE) ? st_ch_q + CHW'(1) : '0;
      if (state_d == S_CONV && state_q != S_CONV) begin
        conv_cnt_q   <= '0;
        period_cnt_q <= '0;
      end else begin
        conv_cnt_q <= conv_cnt_q + CVW'(1);
        if (period_cnt_q != '1) period_cnt_q <= period_cnt_q + 16'd1;
      end
      if (wr_status && OPB_DI[ST_DONE]) st_done_q <= 1'b0;
      if (wr_status && OPB_DI[ST_WRAP]) st_wrap_q <= 1'b0;
      if (state_q == S_IDLE && state_d == S_CONV) begin
        wptr_q     <= '0;
        set_idx_q  <= '0;
        st_done_q  <= 1'b0;
        run_cont_q <= ctrl_cont_nxt;
      end
      if (abort_run) st_done_q <= 1'b1;
      if (set_end) begin
        wptr_q    <= wptr_nxt[AW-1:0];
        set_idx_q <= set_idx_q + SW'(1);
        if (run_cont_q && wptr_nxt[AW]) st_wrap_q <= 1'b1;
        if (run_end) st_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      ctrl_cont_q     <= 1'b0;
      ctrl_testpat_q  <= 1'b0;
      cfg_sclk_half_q <= SCLK_HALF_RST;
      cfg_period_q    <= PERIOD_RST;
      count_q         <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_cont_q <= OPB_DI[CTRL_CONT];
`ifdef ADC_TESTPAT_EN
        ctrl_testpat_q <= OPB_DI[CTRL_TESTPAT];
`endif
      end
      if (wr_cfg) begin
        cfg_sclk_half_q <= OPB_DI[7:0];
        cfg_period_q    <= OPB_DI[31:16];
      end
      if (wr_count) count_q <= OPB_DI[AW-1:0];
    end
  end

  adc_serial_shifter #(
    .NCH(NCH),
    .RES(RES)
  ) u_shifter (
    .clk       (OPB_CLK),
    .rst_n     (OPB_RST_N),
    .start     (shift_start),
    .abort     (abort_run),
    .sclk_half (cfg_sclk_half_q),
    .sdout     (ADC_SDOUT),
    .sclk      (shift_sclk),
    .done      (shift_done),
    .data      (shift_data)
  );

  assign ADC_CNVST = cnvst_q;
  assign ADC_SCLK  = shift_sclk;

  always_comb begin
    sample = '0;
    for (int unsigned c = 0; c < NCH; c++)
      if (st_ch_q == CHW'(c)) sample = shift_data[c];
  end

  assign ram_we    = (state_q == S_STORE) && !abort_req;
  assign ram_waddr = wptr_q + AW'(st_ch_q);
`ifdef ADC_TESTPAT_EN
  assign ram_wdata = ctrl_testpat_q ? {8'(st_ch_q), 8'hA5, 16'(set_idx_q)} : 32'(sample);
`else
  assign ram_wdata = 32'(sample);
`endif

  always_ff @(posedge OPB_CLK) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (OPB_RE) ram_q <= ram[OPB_ADDR[AW+1:2]];
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      REG_CONTROL: begin
        reg_rdata[CTRL_CONT] = ctrl_cont_q;
`ifdef ADC_TESTPAT_EN
        reg_rdata[CTRL_TESTPAT] = ctrl_testpat_q;
`endif
      end
      REG_CONFIG: reg_rdata = {cfg_period_q, 8'h00, cfg_sclk_half_q};
      REG_STATUS: begin
        reg_rdata[31:16]   = 16'(wptr_q);
        reg_rdata[ST_WRAP] = st_wrap_q;
        reg_rdata[ST_DONE] = st_done_q;
        reg_rdata[ST_BUSY] = (state_q != S_IDLE);
      end
      REG_COUNT: reg_rdata[AW-1:0] = count_q;
      default: ;
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      do_reg_q <= '0;
      rd_ram_q <= 1'b0;
    end else begin
      rd_ram_q <= OPB_RE && !OPB_ADDR[11];
      do_reg_q <= (OPB_RE && OPB_ADDR[11]) ? reg_rdata : '0;
    end
  end

  // RAM read register has no reset; rd_ram_q masks it outside a read cycle.
  assign OPB_DO = rd_ram_q ? ram_q : do_reg_q;

  // ctrl_testpat_q is tied off when the pattern feature is not built.
  logic unused_tp;
  assign unused_tp = ctrl_testpat_q;

endmodule

// File: tb/tb_adc_spi_capture_mc.sv
// Directed self-checking bench for adc_spi_capture_mc (NCH=2, RES=16, DEPTH=16).
module tb_adc_spi_capture_mc;

  localparam int NCH = 2;
  localparam int RES = 16;
  localparam logic [31:0] A_CTRL = 32'h800;
  localparam logic [31:0] A_CFG  = 32'h804;
  localparam logic [31:0] A_STAT = 32'h808;
  localparam logic [31:0] A_CNT  = 32'h80C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] di = '0;
  logic we = 1'b0;
  logic re = 1'b0;
  logic [31:0] dout;
  logic cnvst, sclk;
  logic [NCH-1:0] sdout;

  int checks = 0;
  int errors = 0;

  logic [15:0] adc_val [NCH];
  int bitpos = 0;
  logic cnvst_prev = 1'b0;
  logic sclk_prev = 1'b0;

  always #5 clk = ~clk;

  adc_spi_capture_mc #(
    .NCH(2),
    .RES(16),
    .DEPTH(16),
    .T_CONV(70)
  ) dut (
    .OPB_CLK   (clk),
    .OPB_RST_N (rst_n),
    .OPB_ADDR  (addr),
    .OPB_DI    (di),
    .OPB_WE    (we),
    .OPB_RE    (re),
    .OPB_DO    (dout),
    .ADC_CNVST (cnvst),
    .ADC_SCLK  (sclk),
    .ADC_SDOUT (sdout)
  );

  // ADC model: MSB after CNVST falls, next bit after each SCLK fall.
  always @(posedge clk) begin
    #1;
    if (cnvst_prev && !cnvst) bitpos = RES - 1;
    else if (sclk_prev && !sclk && bitpos > 0) bitpos = bitpos - 1;
    cnvst_prev = cnvst;
    sclk_prev = sclk;
    for (int c = 0; c < NCH; c++) sdout[c] = adc_val[c][bitpos];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic opb_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; di = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic opb_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
    d = dout;
  endtask

  task automatic wait_idle(input int max_reads, output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < max_reads; i++) begin
      opb_read(A_STAT, s);
      if (!s[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    checks++; if (cnvst !== 1'b0) begin errors++; $display("FAIL reset_cnvst got %b exp 0", cnvst); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sclk); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_do got %h exp 0", dout); end
    opb_read(A_CTRL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_control got %h exp %h", v, 32'h0); end
    opb_read(A_CFG, v);
    checks++; if (v !== 32'h00C8_0001) begin errors++; $display("FAIL reset_config got %h exp %h", v, 32'h00C8_0001); end
    tick(1);
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL do_idle_zero got %h exp 0", dout); end
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", v, 32'h0); end
    opb_read(A_CNT, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", v, 32'h0); end
    opb_read(32'h810, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", v); end
  endtask

  task automatic test_single_shot();
    logic [31:0] v, exp;
    bit ok;
    adc_val[0] = 16'h1234;
    adc_val[1] = 16'hABCD;
    opb_write(A_CFG, 32'h00C8_0002);
    opb_write(A_CNT, 32'd4);
    opb_write(A_CTRL, 32'h2);
    wait_idle(1200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy exp idle"); end
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0008_0002) begin errors++; $display("FAIL single_status got %h exp %h", v, 32'h0008_0002); end
    for (int w = 0; w < 8; w++) begin
      opb_read(32'(w * 4), v);
      exp = (w % 2 == 0) ? 32'h0000_1234 : 32'h0000_ABCD;
      checks++; if (v !== exp) begin errors++; $display("FAIL single_ram[%0d] got %h exp %h", w, v, exp); end
    end
    opb_write(A_STAT, 32'h2);
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0008_0000) begin errors++; $display("FAIL done_w1c got %h exp %h", v, 32'h0008_0000); end
  endtask

  task automatic test_timing();
    logic [31:0] v;
    logic pc, ps;
    int rise_t [4];
    int rises, pulses, s1, s2, hi_len, cnv_fall;
    pc = 1'b0; ps = 1'b0;
    rises = 0; pulses = 0; s1 = 0; s2 = 0; hi_len = -1; cnv_fall = -1;
    opb_write(A_CNT, 32'd3);
    opb_write(A_CTRL, 32'h2);
    for (int c = 0; c < 600; c++) begin
      if (cnvst && !pc && rises < 4) begin rise_t[rises] = c; rises++; end
      if (!cnvst && pc && cnv_fall < 0) cnv_fall = c;
      if (sclk && !ps && rises == 1) begin
        pulses++;
        if (pulses == 1) s1 = c;
        else if (pulses == 2) s2 = c;
      end
      if (!sclk && ps && pulses == 1 && hi_len < 0) hi_len = c - s1;
      pc = cnvst; ps = sclk;
      tick(1);
    end
    checks++; if (rises !== 3) begin errors++; $display("FAIL cnvst_rises got %0d exp 3", rises); end
    if (rises == 3) begin
      checks++; if (rise_t[1] - rise_t[0] !== 200) begin errors++; $display("FAIL period_1 got %0d exp 200", rise_t[1] - rise_t[0]); end
      checks++; if (rise_t[2] - rise_t[1] !== 200) begin errors++; $display("FAIL period_2 got %0d exp 200", rise_t[2] - rise_t[1]); end
    end
    checks++; if (cnv_fall !== 70) begin errors++; $display("FAIL cnvst_high got %0d exp 70", cnv_fall); end
    checks++; if (pulses !== 16) begin errors++; $display("FAIL sclk_pulses got %0d exp 16", pulses); end
    checks++; if (s2 - s1 !== 4) begin errors++; $display("FAIL sclk_period got %0d exp 4", s2 - s1); end
    checks++; if (hi_len !== 2) begin errors++; $display("FAIL sclk_high got %0d exp 2", hi_len); end
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0006_0002) begin errors++; $display("FAIL timing_status got %h exp %h", v, 32'h0006_0002); end
  endtask

  task automatic test_continuous();
    logic [31:0] v;
    bit ok;
    opb_write(A_CTRL, 32'h6);
    tick(1800);
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0002_0005) begin errors++; $display("FAIL cont_wrap got %h exp %h", v, 32'h0002_0005); end
    opb_write(A_STAT, 32'h4);
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0002_0001) begin errors++; $display("FAIL wrap_w1c got %h exp %h", v, 32'h0002_0001); end
    opb_write(A_CTRL, 32'h0);
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_stop_timeout got busy exp idle"); end
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0004_0002) begin errors++; $display("FAIL cont_stop_status got %h exp %h", v, 32'h0004_0002); end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    opb_write(A_CNT, 32'd4);
    opb_write(A_CTRL, 32'h2);
    tick(250);
    opb_write(A_CTRL, 32'h2);
    tick(40);
    opb_write(A_CTRL, 32'h1);
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk got %b exp 0", sclk); end
    checks++; if (cnvst !== 1'b0) begin errors++; $display("FAIL abort_cnvst got %b exp 0", cnvst); end
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0002_0002) begin errors++; $display("FAIL abort_status got %h exp %h", v, 32'h0002_0002); end
    opb_write(A_CTRL, 32'h3);
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0002_0002) begin errors++; $display("FAIL start_abort_idle got %h exp %h", v, 32'h0002_0002); end
  endtask

  task automatic test_testpat();
    logic [31:0] v;
`ifdef ADC_TESTPAT_EN
    bit ok;
    opb_write(A_CNT, 32'd3);
    opb_write(A_CTRL, 32'hA);
    wait_idle(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL testpat_timeout got busy exp idle"); end
    opb_read(32'd20, v);
    checks++; if (v !== 32'h01A5_0002) begin errors++; $display("FAIL testpat_ram5 got %h exp %h", v, 32'h01A5_0002); end
    opb_read(32'd8, v);
    checks++; if (v !== 32'h00A5_0001) begin errors++; $display("FAIL testpat_ram2 got %h exp %h", v, 32'h00A5_0001); end
    opb_write(A_CTRL, 32'h0);
`else
    opb_write(A_CTRL, 32'h8);
    opb_read(A_CTRL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL testpat_absent got %h exp 0", v); end
    opb_write(A_CTRL, 32'h4);
    opb_read(A_CTRL, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL control_cont_rb got %h exp %h", v, 32'h4); end
    opb_write(A_CTRL, 32'h0);
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bit ok;
    opb_write(A_CNT, 32'd2);
    opb_write(A_CTRL, 32'h2);
    tick(30);
    checks++; if (cnvst !== 1'b1) begin errors++; $display("FAIL midconv_cnvst got %b exp 1", cnvst); end
    rst_n = 1'b0;
    #1;
    checks++; if ({cnvst, sclk} !== 2'b00) begin errors++; $display("FAIL rst_outputs got %b exp 00", {cnvst, sclk}); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_do got %h exp 0", dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", v); end
    opb_read(A_CFG, v);
    checks++; if (v !== 32'h00C8_0001) begin errors++; $display("FAIL rst_config got %h exp %h", v, 32'h00C8_0001); end
    adc_val[0] = 16'h5A5A;
    adc_val[1] = 16'h0F0F;
    opb_write(A_CNT, 32'd1);
    opb_write(A_CTRL, 32'h2);
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_capture_timeout got busy exp idle"); end
    opb_read(32'd0, v);
    checks++; if (v !== 32'h0000_5A5A) begin errors++; $display("FAIL rst_ram0 got %h exp %h", v, 32'h0000_5A5A); end
    opb_read(32'd4, v);
    checks++; if (v !== 32'h0000_0F0F) begin errors++; $display("FAIL rst_ram1 got %h exp %h", v, 32'h0000_0F0F); end
    opb_read(A_STAT, v);
    checks++; if (v !== 32'h0002_0002) begin errors++; $display("FAIL rst_capture_status got %h exp %h", v, 32'h0002_0002); end
  endtask

  initial begin
    adc_val[0] = 16'h0000;
    adc_val[1] = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    test_reset();
    test_single_shot();
    test_timing();
    test_continuous();
    test_abort();
    test_testpat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
